// File: rtl/jtag_hps_bridge_bytes_to_packets_if.sv
// Byte-stream in / packet-stream out bundle for the bytes-to-packets decoder.
// The slave view belongs to the decoder; the master view to whoever drives it.
interface jtag_hps_bridge_bytes_to_packets_if #(
  parameter int CHANNEL_WIDTH = 8
);
  logic                     in_ready;
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     out_ready;
  logic                     out_valid;
  logic [7:0]               out_data;
  logic [CHANNEL_WIDTH-1:0] out_channel;
  logic                     out_startofpacket;
  logic                     out_endofpacket;

  modport slave (
    output in_ready,
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_channel,
    output out_startofpacket,
    output out_endofpacket
  );

  modport master (
    input  in_ready,
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_channel,
    input  out_startofpacket,
    input  out_endofpacket
  );
endinterface

// File: rtl/jtag_hps_bridge_bytes_to_packets.sv
// Strips in-band SOP/EOP/CHAN/ESC framing from the raw JTAG byte stream and
// emits one registered Avalon-ST beat per payload byte.
module jtag_hps_bridge_bytes_to_packets #(
  parameter int         CHANNEL_WIDTH = 8,
  parameter logic [7:0] ESC_XOR       = 8'h20
) (
  input logic clk,
  input logic reset,
  jtag_hps_bridge_bytes_to_packets_if.slave bus
);
  localparam logic [7:0] SOP_C  = 8'h7A;
  localparam logic [7:0] EOP_C  = 8'h7B;
  localparam logic [7:0] CHAN_C = 8'h7C;
  localparam logic [7:0] ESC_C  = 8'h7D;

  logic                     esc_pend;
  logic                     chan_pend;
  logic                     sop_pend;
  logic                     eop_pend;
  logic [CHANNEL_WIDTH-1:0] chan_reg;

  logic                     esc_nxt;
  logic                     chan_pend_nxt;
  logic                     sop_nxt;
  logic                     eop_nxt;
  logic [CHANNEL_WIDTH-1:0] chan_nxt;

  logic       accept;
  logic       emit;
  logic [7:0] emit_data;
  logic [7:0] esc_x;

  assign bus.in_ready = ~bus.out_valid | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign esc_x        = bus.in_data ^ ESC_XOR;

  // Decode the accepted byte into flag updates, channel writes and beats
  always_comb begin
    esc_nxt       = esc_pend;
    chan_pend_nxt = chan_pend;
    sop_nxt       = sop_pend;
    eop_nxt       = eop_pend;
    chan_nxt      = chan_reg;
    emit          = 1'b0;
    emit_data     = bus.in_data;
    if (accept) begin
      if (esc_pend) begin
        esc_nxt   = 1'b0;
        emit_data = esc_x;
        if (chan_pend) begin
          chan_nxt      = CHANNEL_WIDTH'(esc_x);
          chan_pend_nxt = 1'b0;
        end else begin
          emit = 1'b1;
        end
      end else begin
        unique case (1'b1)
          (bus.in_data == ESC_C): begin
            esc_nxt = 1'b1;
          end
          (bus.in_data == SOP_C): begin
            sop_nxt       = 1'b1;
            chan_pend_nxt = 1'b0;
          end
          (bus.in_data == EOP_C): begin
            eop_nxt       = 1'b1;
            chan_pend_nxt = 1'b0;
          end
          (bus.in_data == CHAN_C): begin
            chan_pend_nxt = 1'b1;
          end
          default: begin
            if (chan_pend) begin
              chan_nxt      = CHANNEL_WIDTH'(bus.in_data);
              chan_pend_nxt = 1'b0;
            end else begin
              emit = 1'b1;
            end
          end
        endcase
      end
    end
    if (emit) begin
      sop_nxt = 1'b0;
      eop_nxt = 1'b0;
    end
  end

  // Register decoder state and the outgoing beat; hold it until taken
  always_ff @(posedge clk) begin
    if (reset) begin
      esc_pend              <= 1'b0;
      chan_pend             <= 1'b0;
      sop_pend              <= 1'b0;
      eop_pend              <= 1'b0;
      chan_reg              <= '0;
      bus.out_valid         <= 1'b0;
      bus.out_data          <= '0;
      bus.out_channel       <= '0;
      bus.out_startofpacket <= 1'b0;
      bus.out_endofpacket   <= 1'b0;
    end else begin
      esc_pend  <= esc_nxt;
      chan_pend <= chan_pend_nxt;
      sop_pend  <= sop_nxt;
      eop_pend  <= eop_nxt;
      chan_reg  <= chan_nxt;
      if (emit) begin
        bus.out_valid         <= 1'b1;
        bus.out_data          <= emit_data;
        bus.out_channel       <= chan_nxt;
        bus.out_startofpacket <= sop_pend;
        bus.out_endofpacket   <= eop_pend;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule
